pingpong_output_ram: RTL
========================

PINGPONG_OUTPUT_RAM -- requirements
Module: pingpong_output_ram

Interface
REQ-001 SHALL have parameter ADD_SIZE, default 11, meaning word-address width per bank; bank depth is 2**ADD_SIZE.
REQ-002 SHALL have parameter DATA_SIZE, default 32, meaning word width in bits; a multiple of 8.
REQ-003 SHALL have parameter NUM_BANKS, fixed at 2, meaning ping-pong bank count.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port write_en, input, 1, write strobe.
REQ-007 SHALL have port write_address, input, ADD_SIZE, word address within the writer bank.
REQ-008 SHALL have port write_data_in, input, DATA_SIZE, write data.
REQ-009 SHALL have port write_strb, input, DATA_SIZE/8, byte enables; bit i enables byte i.
REQ-010 SHALL have port write_frame_done, input, 1, pulse marking the writer bank complete.
REQ-011 SHALL have port read_en, input, 1, read strobe.
REQ-012 SHALL have port read_address, input, ADD_SIZE, word address within the reader bank.
REQ-013 SHALL have port read_frame_done, input, 1, pulse releasing the reader bank.
REQ-014 SHALL have port read_data_out, output, DATA_SIZE, registered read data.
REQ-015 SHALL have port read_valid, output, 1, high for one cycle when read_data_out is new.
REQ-016 SHALL have port wr_ready, output, 1, high when the writer bank is free to fill.
REQ-017 SHALL have port rd_ready, output, 1, high when the reader bank holds a complete frame.
REQ-018 SHALL have port err_clear, input, 1, synchronous clear of sticky errors.
REQ-019 SHALL have port wr_overflow_err and rd_underflow_err, outputs, 1 each, sticky error flags.

Function
REQ-020 SHALL keep wr_sel, rd_sel (bank pointers) and full[1:0] (per-bank complete flags).
REQ-021 SHALL drive wr_ready = !full[wr_sel] and rd_ready = full[rd_sel], combinationally.
REQ-022 SHALL accept a write only when write_en && wr_ready, updating only the strobed bytes of bank wr_sel at write_address.
REQ-023 SHALL drop a write issued while !wr_ready and set wr_overflow_err the next cycle.
REQ-024 SHALL, on write_frame_done && wr_ready, set full[wr_sel] and toggle wr_sel; a write in the same cycle lands in the old bank.
REQ-025 SHALL ignore write_frame_done while !wr_ready and set wr_overflow_err.
REQ-026 SHALL accept a read only when read_en && rd_ready; read_data_out and read_valid update exactly one cycle later.
REQ-027 SHALL drop a read issued while !rd_ready, hold read_data_out, keep read_valid low and set rd_underflow_err.
REQ-028 SHALL, on read_frame_done && rd_ready, clear full[rd_sel] and toggle rd_sel; a read in the same cycle completes from the old bank.
REQ-029 SHALL ignore read_frame_done while !rd_ready and set rd_underflow_err.
REQ-030 SHALL apply simultaneous write_frame_done and read_frame_done independently; they never target the same bank while both are legal.
REQ-031 SHALL hold read_data_out between accepted reads.
REQ-032 SHALL clear both error flags on err_clear; a new error in the same cycle wins.
REQ-033 SHALL never address the same bank from both ports, so read-during-write collisions are impossible by construction.

Reset
REQ-034 SHALL, while rst is low, force wr_sel=0, rd_sel=0, full=0, read_data_out=0, read_valid=0 and both error flags to 0, independent of clk.
REQ-035 SHALL leave RAM contents unreset; a bank is readable only after a write_frame_done.
REQ-036 SHALL discard any partially filled frame and in-flight read when reset is asserted mid-operation.

Structure
REQ-037 SHALL put default ADD_SIZE, default DATA_SIZE, NUM_BANKS and a status struct (wr_ready, rd_ready, errors) in the shared package pingpong_ram_pkg.
REQ-038 SHALL instantiate sub-module sdp_ram_bank (simple dual-port, byte-enable write, registered read) once per bank.

Verification
REQ-039 SHALL pass this scenario: fill bank0 with addr i gets data i for i=0..7, pulse write_frame_done -> rd_ready=1, wr_ready=1; read addr 5 -> read_data_out=5 with read_valid one cycle later.
REQ-040 SHALL pass this scenario: write 0xAABBCCDD with strobe 0xF, then 0x11223344 with strobe 0x3, to the same address -> read returns 0xAABB3344.
REQ-041 SHALL pass this scenario: complete two frames without any read_frame_done, then write -> write dropped, wr_overflow_err=1, wr_ready=0; err_clear -> 0.
REQ-042 SHALL pass this scenario: read_en at reset exit with no frame -> read_valid stays 0, rd_underflow_err=1, read_data_out=0.
REQ-043 SHALL pass this scenario: write_frame_done (bank1) and read_frame_done (bank0) in the same cycle -> full=2'b10, wr_sel=0, rd_sel=1.
REQ-044 SHALL pass this scenario: assert rst mid-fill after 3 writes -> all outputs reset immediately, rd_ready=0, wr_ready=1.

Source files
------------

// File: rtl/pingpong_ram_pkg.sv
// Shared defaults and status bundle for the ping-pong output RAM.
package pingpong_ram_pkg;

    localparam int DEFAULT_ADD_SIZE  = 11;
    localparam int DEFAULT_DATA_SIZE = 32;
    localparam int NUM_BANKS         = 2;

    typedef struct packed {
        logic wr_ready;
        logic rd_ready;
        logic wr_overflow_err;
        logic rd_underflow_err;
    } status_t;

endpackage

// File: rtl/sdp_ram_bank.sv
// One simple dual-port RAM bank: byte-enabled write port, registered read port.
module sdp_ram_bank
    import pingpong_ram_pkg::*;
#(
    parameter int ADD_SIZE  = DEFAULT_ADD_SIZE,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADD_SIZE-1:0]    wr_addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic [DATA_SIZE/8-1:0] wr_strb,
    input  logic                   rd_en,
    input  logic [ADD_SIZE-1:0]    rd_addr,
    output logic [DATA_SIZE-1:0]   rd_data
);

    localparam int DEPTH     = 2 ** ADD_SIZE;
    localparam int NUM_LANES = DATA_SIZE / 8;

    // Each byte lane owns its own array so byte enables map onto independent RAM columns.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q_reg;

        always_ff @(posedge clk) begin
            if (wr_en && wr_strb[gi]) begin
                mem[wr_addr] <= wr_data[gi*8 +: 8];
            end
            if (rd_en) begin
                q_reg <= mem[rd_addr];
            end
        end

        assign rd_data[gi*8 +: 8] = q_reg;
    end

endmodule

// File: rtl/pingpong_output_ram.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader drains the other.
module pingpong_output_ram
    import pingpong_ram_pkg::*;
#(
    parameter int ADD_SIZE  = DEFAULT_ADD_SIZE,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int NUM_BANKS = pingpong_ram_pkg::NUM_BANKS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en,
    input  logic [ADD_SIZE-1:0]    write_address,
    input  logic [DATA_SIZE-1:0]   write_data_in,
    input  logic [DATA_SIZE/8-1:0] write_strb,
    input  logic                   write_frame_done,
    input  logic                   read_en,
    input  logic [ADD_SIZE-1:0]    read_address,
    input  logic                   read_frame_done,
    output logic [DATA_SIZE-1:0]   read_data_out,
    output logic                   read_valid,
    output logic                   wr_ready,
    output logic                   rd_ready,
    input  logic                   err_clear,
    output logic                   wr_overflow_err,
    output logic                   rd_underflow_err
);

    logic                 wr_sel_reg, wr_sel_next;
    logic                 rd_sel_reg, rd_sel_next;
    logic [NUM_BANKS-1:0] full_reg, full_next;
    logic                 read_valid_reg;
    logic                 last_bank_reg;
    logic                 have_data_reg;
    logic                 wr_overflow_reg, wr_overflow_next;
    logic                 rd_underflow_reg, rd_underflow_next;
    logic                 write_ok, read_ok, wfd_ok, rfd_ok;
    logic [DATA_SIZE-1:0] bank_rd_data [NUM_BANKS];
    status_t              status;

    assign status.wr_ready         = !full_reg[wr_sel_reg];
    assign status.rd_ready         = full_reg[rd_sel_reg];
    assign status.wr_overflow_err  = wr_overflow_reg;
    assign status.rd_underflow_err = rd_underflow_reg;

    assign write_ok = write_en && status.wr_ready;
    assign wfd_ok   = write_frame_done && status.wr_ready;
    assign read_ok  = read_en && status.rd_ready;
    assign rfd_ok   = read_frame_done && status.rd_ready;

    always_comb begin
        full_next         = full_reg;
        wr_sel_next       = wr_sel_reg;
        rd_sel_next       = rd_sel_reg;
        wr_overflow_next  = wr_overflow_reg;
        rd_underflow_next = rd_underflow_reg;
        // A legal write-done and read-done always hit different banks, so both may apply.
        if (wfd_ok) begin
            full_next[wr_sel_reg] = 1'b1;
            wr_sel_next           = !wr_sel_reg;
        end
        if (rfd_ok) begin
            full_next[rd_sel_reg] = 1'b0;
            rd_sel_next           = !rd_sel_reg;
        end
        if (err_clear) begin
            wr_overflow_next  = 1'b0;
            rd_underflow_next = 1'b0;
        end
        if ((write_en || write_frame_done) && !status.wr_ready) begin
            wr_overflow_next = 1'b1;
        end
        if ((read_en || read_frame_done) && !status.rd_ready) begin
            rd_underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_reg       <= 1'b0;
            rd_sel_reg       <= 1'b0;
            full_reg         <= '0;
            read_valid_reg   <= 1'b0;
            last_bank_reg    <= 1'b0;
            have_data_reg    <= 1'b0;
            wr_overflow_reg  <= 1'b0;
            rd_underflow_reg <= 1'b0;
        end else begin
            wr_sel_reg       <= wr_sel_next;
            rd_sel_reg       <= rd_sel_next;
            full_reg         <= full_next;
            read_valid_reg   <= read_ok;
            wr_overflow_reg  <= wr_overflow_next;
            rd_underflow_reg <= rd_underflow_next;
            if (read_ok) begin
                last_bank_reg <= rd_sel_reg;
                have_data_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        localparam logic BANK_ID = 1'(gi);

        sdp_ram_bank #(
            .ADD_SIZE (ADD_SIZE),
            .DATA_SIZE(DATA_SIZE)
        ) u_bank (
            .clk    (clk),
            .wr_en  (write_ok && (wr_sel_reg == BANK_ID)),
            .wr_addr(write_address),
            .wr_data(write_data_in),
            .wr_strb(write_strb),
            .rd_en  (read_ok && (rd_sel_reg == BANK_ID)),
            .rd_addr(read_address),
            .rd_data(bank_rd_data[gi])
        );
    end

    // Bank output registers hold between reads; the flag masks unreset RAM contents after reset.
    assign read_data_out    = have_data_reg ? bank_rd_data[last_bank_reg] : '0;
    assign read_valid       = read_valid_reg;
    assign wr_ready         = status.wr_ready;
    assign rd_ready         = status.rd_ready;
    assign wr_overflow_err  = status.wr_overflow_err;
    assign rd_underflow_err = status.rd_underflow_err;

endmodule
